// File: rtl/cla_mp_seq.sv
// cla_mp_seq: multi-precision add/subtract sequencer built around one
// 32-bit carry-lookahead adder, processing one word per cycle, LSW first.
//
// Ports:
//   clk   in  1   rising-edge clock
//   rst   in  1   synchronous active-high reset
//   start in  1   request, sampled only in IDLE
//   sub   in  1   0 = a+b, 1 = a-b (sampled with start)
//   a, b  in  W   operands, W = 32*WORDS (sampled with start)
//   busy  out 1   high in RUN and DONE
//   done  out 1   one-cycle pulse, result valid
//   sum   out W   result register
//   cout  out 1   final carry (sub: 1 = no borrow)
//   ovf   out 1   signed overflow of the W-bit result
//   zero  out 1   result == 0 (only with CLA_MP_SEQ_ZERO_FLAG_EN)
//
// Parameter WORDS: 32-bit words per operand, legal range 2..16.
// Optional feature macro: CLA_MP_SEQ_ZERO_FLAG_EN adds the zero port.

module CLA_32bit (
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic        i_cin,
    output logic [31:0] o_sum,
    output logic        o_cout,
    output logic        o_gp,
    output logic        o_gg
);
    logic [31:0] w_p;
    logic [31:0] w_g;
    logic [31:0] w_c;
    logic [7:0]  w_bp;
    logic [7:0]  w_bg;
    logic [8:0]  w_bc;
    logic        w_gacc;

    // Two-level lookahead: 4-bit groups produce group P/G,
    // group carries come from the second level, then bit
    // carries are expanded inside each group from its carry-in.
    always_comb begin
        w_p    = i_a ^ i_b;
        w_g    = i_a & i_b;
        w_bp   = '0;
        w_bg   = '0;
        w_bc   = '0;
        w_c    = '0;
        w_gacc = 1'b0;

        for (int k = 0; k < 8; k++) begin
            w_bp[k] = &w_p[4*k +: 4];
            w_bg[k] = w_g[4*k+3]
                    | (w_p[4*k+3] & w_g[4*k+2])
                    | (w_p[4*k+3] & w_p[4*k+2] & w_g[4*k+1])
                    | ((&w_p[4*k+1 +: 3]) & w_g[4*k]);
        end

        w_bc[0] = i_cin;
        for (int k = 0; k < 8; k++) begin
            w_bc[k+1] = w_bg[k] | (w_bp[k] & w_bc[k]);
        end

        for (int k = 0; k < 8; k++) begin
            w_c[4*k]   = w_bc[k];
            w_c[4*k+1] = w_g[4*k]
                       | (w_p[4*k] & w_bc[k]);
            w_c[4*k+2] = w_g[4*k+1]
                       | (w_p[4*k+1] & w_g[4*k])
                       | (w_p[4*k+1] & w_p[4*k] & w_bc[k]);
            w_c[4*k+3] = w_g[4*k+2]
                       | (w_p[4*k+2] & w_g[4*k+1])
                       | (w_p[4*k+2] & w_p[4*k+1] & w_g[4*k])
                       | (w_p[4*k+2] & w_p[4*k+1] & w_p[4*k]
                          & w_bc[k]);
        end

        // Whole-word generate, independent of the carry-in.
        w_gacc = w_bg[0];
        for (int k = 1; k < 8; k++) begin
            w_gacc = w_bg[k] | (w_bp[k] & w_gacc);
        end
    end

    assign o_sum  = w_p ^ w_c;
    assign o_cout = w_bc[8];
    assign o_gp   = &w_bp;
    assign o_gg   = w_gacc;
endmodule

module cla_mp_seq #(
    parameter int WORDS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  sub,
    input  logic [32*WORDS-1:0]   a,
    input  logic [32*WORDS-1:0]   b,
    output logic                  busy,
    output logic                  done,
    output logic [32*WORDS-1:0]   sum,
    output logic                  cout,
    output logic                  ovf
`ifdef CLA_MP_SEQ_ZERO_FLAG_EN
    ,
    output logic                  zero
`endif
);
    localparam int W  = 32 * WORDS;
    localparam int IW = $clog2(WORDS);
    localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nx;
    logic [IW-1:0]   r_idx;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic            r_sub;
    logic            r_carry;
    logic [W-1:0]    r_sum;
    logic            r_cout;
    logic            r_ovf;
`ifdef CLA_MP_SEQ_ZERO_FLAG_EN
    logic            r_zero;
`endif

    logic [31:0]     w_a_word;
    logic [31:0]     w_b_mod;
    logic [31:0]     w_add_sum;
    logic            w_add_cout;
    logic            w_last;
    logic            w_accept;
    logic [IW+4:0]   w_base;

    // Word base offset = idx*32, built by concatenation.
    assign w_base   = {r_idx, 5'b0};
    assign w_a_word = r_a[w_base +: 32];
    // Subtraction is a + ~b + 1; the +1 enters as the
    // initial carry loaded at start.
    assign w_b_mod  = r_b[w_base +: 32] ^ {32{r_sub}};
    assign w_last   = (r_idx == LAST);
    assign w_accept = (r_state == S_IDLE) && start;

    CLA_32bit u_cla (
        .i_a    (w_a_word),
        .i_b    (w_b_mod),
        .i_cin  (r_carry),
        .o_sum  (w_add_sum),
        .o_cout (w_add_cout),
        .o_gp   (),
        .o_gg   ()
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        busy       = 1'b0;
        done       = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nx = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (w_last) begin
                    w_state_nx = S_DONE;
                end
            end
            S_DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                w_state_nx = S_IDLE;
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_sub   <= 1'b0;
            r_carry <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
`ifdef CLA_MP_SEQ_ZERO_FLAG_EN
            r_zero  <= 1'b0;
`endif
        end else if (w_accept) begin
            r_a     <= a;
            r_b     <= b;
            r_sub   <= sub;
            r_carry <= sub;
            r_idx   <= '0;
`ifdef CLA_MP_SEQ_ZERO_FLAG_EN
            r_zero  <= 1'b1;
`endif
        end else if (r_state == S_RUN) begin
            r_sum[w_base +: 32] <= w_add_sum;
            r_carry             <= w_add_cout;
            // Wrap to 0 after the last word so idx stays
            // in range for non-power-of-two WORDS.
            r_idx <= w_last ? '0 : r_idx + IW'(1);
`ifdef CLA_MP_SEQ_ZERO_FLAG_EN
            r_zero <= r_zero & ~(|w_add_sum);
`endif
            if (w_last) begin
                r_cout <= w_add_cout;
                r_ovf  <= (w_a_word[31] == w_b_mod[31])
                       && (w_add_sum[31] != w_a_word[31]);
            end
        end
    end

    assign sum  = r_sum;
    assign cout = r_cout;
    assign ovf  = r_ovf;
`ifdef CLA_MP_SEQ_ZERO_FLAG_EN
    assign zero = r_zero;
`endif
endmodule

// File: tb/tb_cla_mp_seq.sv
// tb_cla_mp_seq: self-checking bench for cla_mp_seq (WORDS=4),
// vector table plus scoreboard, with abort/start-ignore sequences.
module tb_cla_mp_seq;
    localparam int WORDS = 4;
    localparam int W     = 128;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         sub = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
`ifdef CLA_MP_SEQ_ZERO_FLAG_EN
    logic         zero;
`endif

    cla_mp_seq #(.WORDS(WORDS)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .sub   (sub),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
`ifdef CLA_MP_SEQ_ZERO_FLAG_EN
        ,
        .zero  (zero)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] s;
        logic         c;
        logic         o;
        logic         z;
    } exp_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sub;
        logic [W-1:0] s;
        logic         c;
        logic         o;
    } vec_t;

    exp_t sb[$];
    vec_t vt[8];
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   done_cnt = 0;
    int   last_done = -1;
    bit   spacing_en = 1'b0;

    always @(posedge clk) cyc++;

    task automatic check(input string nm,
                         input logic [W-1:0] act,
                         input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] x,
                                   input logic [W-1:0] y,
                                   input logic s);
        logic [W:0] r;
        exp_t e;
        if (s) r = {1'b0, x} + {1'b0, ~y} + 129'd1;
        else   r = {1'b0, x} + {1'b0, y};
        e.s = r[W-1:0];
        e.c = r[W];
        if (s) e.o = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
        else   e.o = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
        e.z = (r[W-1:0] == '0);
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (done) begin
            done_cnt++;
            if (sb.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                e = sb.pop_front();
                check("sum", sum, e.s);
                check("cout", W'(cout), W'(e.c));
                check("ovf", W'(ovf), W'(e.o));
`ifdef CLA_MP_SEQ_ZERO_FLAG_EN
                check("zero", W'(zero), W'(e.z));
`endif
            end
            if (spacing_en) begin
                if (last_done >= 0)
                    check("done_spacing", W'(cyc - last_done), W'(WORDS + 2));
                last_done = cyc;
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 20) check("idle_timeout", 1, 0);
    endtask

    task automatic run_op(input logic [W-1:0] ta,
                          input logic [W-1:0] tb2,
                          input logic ts,
                          input logic [W-1:0] es,
                          input logic ec,
                          input logic eo);
        int n;
        exp_t e;
        wait_idle();
        a = ta; b = tb2; sub = ts; start = 1'b1;
        e.s = es; e.c = ec; e.o = eo; e.z = (es == '0);
        sb.push_back(e);
        @(posedge clk); #1;
        start = 1'b0;
        a = ~ta; b = {$urandom, $urandom, $urandom, $urandom}; sub = ~ts;
        n = 1;
        while (!done && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("latency", W'(n), W'(WORDS + 1));
    endtask

    initial begin
        int d0;
        int n;
        exp_t e;

        vt[0] = '{{4{32'hFFFFFFFF}}, 128'd1, 1'b0, 128'd0, 1'b1, 1'b0};
        vt[1] = '{128'h00000001_00000000_00000000_00000000, 128'd1, 1'b1,
                  128'h00000000_FFFFFFFF_FFFFFFFF_FFFFFFFF, 1'b1, 1'b0};
        vt[2] = '{128'h7FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF, 128'd1, 1'b0,
                  128'h80000000_00000000_00000000_00000000, 1'b0, 1'b1};
        vt[3] = '{128'd5, 128'd7, 1'b1,
                  128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE, 1'b0, 1'b0};
        vt[4] = '{128'd0, 128'd0, 1'b0, 128'd0, 1'b0, 1'b0};
        vt[5] = '{128'h80000000_00000000_00000000_00000000, 128'd1, 1'b1,
                  128'h7FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF, 1'b1, 1'b1};
        vt[6] = '{128'd0, 128'd0, 1'b1, 128'd0, 1'b1, 1'b0};
        vt[7] = '{128'h00000000_00000000_00000000_FFFFFFFF, 128'd1, 1'b0,
                  128'h00000000_00000000_00000001_00000000, 1'b0, 1'b0};

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_busy", W'(busy), 0);
        check("rst_done", W'(done), 0);
        check("rst_sum", sum, 0);
        check("rst_cout", W'(cout), 0);
        check("rst_ovf", W'(ovf), 0);

        // rst and start together: start dropped
        rst = 1'b1; start = 1'b1; a = 128'd1; b = 128'd1;
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;
        @(posedge clk); #1;
        check("rst_start_busy", W'(busy), 0);

        for (int i = 0; i < 8; i++)
            run_op(vt[i].a, vt[i].b, vt[i].sub, vt[i].s, vt[i].c, vt[i].o);

        // results hold after done
        repeat (3) @(posedge clk);
        #1;
        check("hold_sum", sum, vt[7].s);
        check("hold_busy", W'(busy), 0);

        // start pulsed throughout RUN: one op only
        wait_idle();
        d0 = done_cnt;
        a = 128'd5; b = 128'd7; sub = 1'b1; start = 1'b1;
        e = model(128'd5, 128'd7, 1'b1);
        sb.push_back(e);
        @(posedge clk); #1;
        n = 0;
        while (!done && n < 20) begin
            a = {$urandom, $urandom, $urandom, $urandom};
            b = {$urandom, $urandom, $urandom, $urandom};
            sub = 1'($urandom);
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("ignored_start_dones", W'(done_cnt - d0), 1);
        check("ignored_start_busy", W'(busy), 0);

        // abort in second RUN cycle
        a = 128'd3; b = 128'd4; sub = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_busy", W'(busy), 0);
        check("abort_done", W'(done), 0);
        check("abort_sum", sum, 0);
        check("abort_cout", W'(cout), 0);
        run_op(128'd3, 128'd4, 1'b0, 128'd7, 1'b0, 1'b0);

        // back-to-back random ops
        wait_idle();
        @(posedge clk); #1;
        last_done = -1;
        spacing_en = 1'b1;
        start = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            wait_idle();
            a = {$urandom, $urandom, $urandom, $urandom};
            b = {$urandom, $urandom, $urandom, $urandom};
            if (i % 8 == 0) b = a;
            if (i % 16 == 3) a = '1;
            sub = 1'($urandom);
            sb.push_back(model(a, b, sub));
            @(posedge clk); #1;
        end
        start = 1'b0;
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        @(negedge clk);
        spacing_en = 1'b0;
        check("drain", W'(sb.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule
